// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state codes, start/ready
// levels and the double-width HI/LO result bus type.
package div_unit_pkg;

    // Divider FSM state codes.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Request and result-valid levels as seen by the EX stage.
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // {hi, lo} bus written by MEM/WB.
    localparam int DoubleRegBusW = 64;
    typedef logic [DoubleRegBusW-1:0] double_reg_bus_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, try to
// subtract the divisor from the widened remainder, keep it if non-negative.
module div_unit_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] rem_quo,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W-1:0] rem_quo_next
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W:0]   trial;

    // The shifted remainder needs one extra bit, so the trial subtract is
    // DATA_W+1 wide; its MSB is the borrow that decides restore vs. keep.
    always_comb begin
        shifted = {rem_quo, 1'b0};
        trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
        if (!trial[DATA_W]) begin
            rem_quo_next = {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
        end else begin
            rem_quo_next = shifted[2*DATA_W-1:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Result is {remainder, quotient}; ready_o stays high while start_i is held.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam logic [DATA_W-1:0] ZERO_W = '0;

    div_state_e          state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [2*DATA_W-1:0] work_reg, work_next;
    logic [DATA_W-1:0]   divisor_reg, divisor_next;
    logic                neg_quo_reg, neg_quo_next;
    logic                neg_rem_reg, neg_rem_next;
    logic [2*DATA_W-1:0] result_reg, result_next;
    logic                ready_reg, ready_next;

    logic [2*DATA_W-1:0] step_out;
    logic                sign1, sign2;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W-1:0]   quo_fixed, rem_fixed;

    div_unit_step #(.DATA_W(DATA_W)) u_step (
        .rem_quo      (work_reg),
        .divisor      (divisor_reg),
        .rem_quo_next (step_out)
    );

    // Operand magnitudes and final sign fix-up (wrapping mod 2^DATA_W).
    always_comb begin
        sign1     = signed_div_i & opdata1_i[DATA_W-1];
        sign2     = signed_div_i & opdata2_i[DATA_W-1];
        abs1      = sign1 ? (ZERO_W - opdata1_i) : opdata1_i;
        abs2      = sign2 ? (ZERO_W - opdata2_i) : opdata2_i;
        quo_fixed = neg_quo_reg ? (ZERO_W - work_reg[DATA_W-1:0]) : work_reg[DATA_W-1:0];
        rem_fixed = neg_rem_reg ? (ZERO_W - work_reg[2*DATA_W-1:DATA_W])
                                : work_reg[2*DATA_W-1:DATA_W];
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        neg_quo_next = neg_quo_reg;
        neg_rem_next = neg_rem_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;
        case (state_reg)
            DivFree: begin
                result_next = '0;
                ready_next  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    work_next    = {ZERO_W, abs1};
                    divisor_next = abs2;
                    neg_quo_next = sign1 ^ sign2;
                    neg_rem_next = sign1;
                    cnt_next     = '0;
                    state_next   = (opdata2_i == ZERO_W) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                // Architecturally undefined; fixed to all-zero here.
                result_next = '0;
                ready_next  = DivResultReady;
                state_next  = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    work_next  = '0;
                    cnt_next   = '0;
                    state_next = DivFree;
                end else if (cnt_reg < CNT_W'(DATA_W)) begin
                    work_next = step_out;
                    cnt_next  = cnt_reg + 1'b1;
                end else begin
                    result_next = {rem_fixed, quo_fixed};
                    ready_next  = DivResultReady;
                    state_next  = DivEnd;
                end
            end
            DivEnd: begin
                // annul_i is ignored: EX has already committed the result.
                if (start_i == DivStop) begin
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                    state_next  = DivFree;
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
    end

    // State, working and output registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= DivFree;
            cnt_reg     <= '0;
            work_reg    <= '0;
            divisor_reg <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DivResultNotReady;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            neg_quo_reg <= neg_quo_next;
            neg_rem_reg <= neg_rem_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule
